// File: rtl/ram_arbiter.sv
// Two-port round-robin front end for a single-port, async-read RAM.
// After reset an optional sequencer zero-fills the RAM before any grant is issued.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int RAM_WIDTH  = 8,
    parameter int INIT_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [15:0]           a_wdata,
    output logic                  a_gnt,
    output logic [15:0]           a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [15:0]           b_wdata,
    output logic                  b_gnt,
    output logic [15:0]           b_rdata,
    output logic                  b_rvalid,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_load,
    output logic [15:0]           ram_in,
    input  logic [15:0]           ram_out,
    output logic                  init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    localparam logic                  SKIP_FILL = (INIT_EN == 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_WIDTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  last_b_q, last_b_d;
    logic                  init_done_q, init_done_d;
    logic [15:0]           a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic                  a_sel, b_sel;

    // On a tie the requester that was not served last wins.
    assign a_sel = (state_q == ST_RUN) && a_req && (!b_req || last_b_q);
    assign b_sel = (state_q == ST_RUN) && b_req && !a_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKIP_FILL ? ST_RUN : ST_INIT;
            cnt_q       <= '0;
            last_b_q    <= 1'b1;
            init_done_q <= SKIP_FILL;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            init_done_q <= init_done_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_b_d    = last_b_q;
        init_done_d = init_done_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (a_sel) begin
                    last_b_d = 1'b0;
                    if (!a_we) begin
                        a_rdata_d  = ram_out;
                        a_rvalid_d = 1'b1;
                    end
                end
                if (b_sel) begin
                    last_b_d = 1'b1;
                    if (!b_we) begin
                        b_rdata_d  = ram_out;
                        b_rvalid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Load and grants are gated by rst_n so nothing leaks out while reset is held.
    always_comb begin
        ram_address = a_addr;
        ram_in      = '0;
        ram_load    = 1'b0;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        if (state_q == ST_INIT) begin
            ram_address = cnt_q;
            ram_load    = rst_n;
        end else if (a_sel) begin
            ram_address = a_addr;
            ram_in      = a_wdata;
            ram_load    = a_we & rst_n;
            a_gnt       = rst_n;
        end else if (b_sel) begin
            ram_address = b_addr;
            ram_in      = b_wdata;
            ram_load    = b_we & rst_n;
            b_gnt       = rst_n;
        end
    end

    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign init_done = init_done_q;

endmodule
